// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: splits byte/half/word requests into little-endian byte beats.
// Latency N+1 cycles to rspValid (N beats, no wait states); backpressure: reqReady low in BEAT/RESP, memAck stalls beats.
module lsu_byte_master #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_ctrl,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t              r_state;
    logic                r_write;
    logic [2:0]          r_ctrl;
    logic [31:0]         r_wdata;
    logic [1:0]          r_cnt;
    logic [1:0]          r_last;
    logic [31:0]         r_asm;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_err;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;

    logic                w_err;
    logic [1:0]          w_last;
    logic [31:0]         w_asm_next;
    logic [31:0]         w_rsp_load;

    always_comb begin
        w_err = 1'b0;
        case (i_req_ctrl)
            3'b011, 3'b110, 3'b111: w_err = 1'b1;
            default: ;
        endcase
        if (i_req_write && i_req_ctrl[2])
            w_err = 1'b1;
        if (CHECK_ALIGN && (i_req_ctrl[1:0] == 2'b01) && i_req_addr[0])
            w_err = 1'b1;
        if (CHECK_ALIGN && (i_req_ctrl[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00))
            w_err = 1'b1;
    end

    always_comb begin
        case (i_req_ctrl[1:0])
            2'b00:   w_last = 2'd0;
            2'b01:   w_last = 2'd1;
            default: w_last = 2'd3;
        endcase
    end

    // Assembly including the byte arriving this cycle, so the last beat can respond directly.
    always_comb begin
        w_asm_next = r_asm;
        if (!r_write)
            w_asm_next[{r_cnt, 3'b000} +: 8] = i_mem_rdata;
        case (r_ctrl)
            3'b000:  w_rsp_load = {{24{w_asm_next[7]}}, w_asm_next[7:0]};
            3'b001:  w_rsp_load = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
            3'b100:  w_rsp_load = {24'h0, w_asm_next[7:0]};
            3'b101:  w_rsp_load = {16'h0, w_asm_next[15:0]};
            default: w_rsp_load = w_asm_next;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_ctrl      <= 3'b000;
            r_wdata     <= 32'h0;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_asm       <= 32'h0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_write     <= i_req_write;
                        r_ctrl      <= i_req_ctrl;
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= 2'd0;
                        r_last      <= w_last;
                        r_asm       <= 32'h0;
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'h0;
                        end else begin
                            r_state     <= BEAT;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_req_write;
                            r_mem_addr  <= i_req_addr;
                            r_mem_wdata <= i_req_wdata[7:0];
                        end
                    end
                end
                BEAT: begin
                    if (i_mem_ack) begin
                        r_asm <= w_asm_next;
                        if (r_cnt == r_last) begin
                            r_state     <= RESP;
                            r_mem_req   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= r_write ? 32'h0 : w_rsp_load;
                        end else begin
                            // r_wdata is kept shifted so the next byte is always at [15:8].
                            r_cnt       <= r_cnt + 2'd1;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                            r_mem_wdata <= r_wdata[15:8];
                            r_wdata     <= r_wdata >> 8;
                        end
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench: instance a checks alignment, instance b does not (used for the wrap-around word load).
module tb_lsu_byte_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_valid, b_req_valid;
    logic        req_write;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr, req_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we;
    logic [31:0] a_rsp_data, a_mem_addr;
    logic [7:0]  a_mem_wdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we;
    logic [31:0] b_rsp_data, b_mem_addr;
    logic [7:0]  b_mem_wdata;

    lsu_byte_master #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_write(req_write), .i_req_ctrl(req_ctrl), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(a_rsp_valid), .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err),
        .o_mem_req(a_mem_req), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata));

    lsu_byte_master #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_write(req_write), .i_req_ctrl(req_ctrl), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(b_rsp_valid), .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err),
        .o_mem_req(b_mem_req), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata));

    initial forever #5 clk = ~clk;

    typedef struct {logic [31:0] data; logic err; int lat;} rsp_t;
    typedef struct {logic [31:0] addr; logic we; logic [7:0] wd;} beat_t;

    rsp_t        a_expq[$], b_expq[$];
    beat_t       beatq[$];
    logic [7:0]  rdq[$];
    rsp_t        ea, eb;
    beat_t       eb_beat;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, acc_cyc = 0;
    int          wait_n = 0, wcnt = 0;
    bit          a_chk_ready = 1'b0;
    logic [31:0] m_addr;
    logic [7:0]  m_wd;
    logic        m_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input bit we, input logic [2:0] c, input logic [31:0] a, input bit al);
        return (c == 3'd3) || (c == 3'd6) || (c == 3'd7) || (we && (c == 3'd4 || c == 3'd5)) ||
               (al && (c == 3'd1 || c == 3'd5) && a[0]) || (al && c == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic int nbeats(input logic [2:0] c);
        return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] c, input logic [31:0] v);
        case (c)
            3'd0:    return {{24{v[7]}}, v[7:0]};
            3'd1:    return {{16{v[15]}}, v[15:0]};
            3'd4:    return {24'h0, v[7:0]};
            3'd5:    return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Memory model: acks after wait_n stalled cycles, checks each beat (every stalled cycle too).
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (a_mem_req || b_mem_req) begin
            m_addr = b_mem_req ? b_mem_addr : a_mem_addr;
            m_we   = b_mem_req ? b_mem_we : a_mem_we;
            m_wd   = b_mem_req ? b_mem_wdata : a_mem_wdata;
            if (beatq.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
                mem_ack = 1'b1;
            end else begin
                eb_beat = beatq[0];
                check("beat_addr", m_addr, eb_beat.addr);
                check("beat_we", {31'h0, m_we}, {31'h0, eb_beat.we});
                check("beat_wdata", {24'h0, m_wd}, {24'h0, eb_beat.wd});
                if (wcnt >= wait_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = (!eb_beat.we && rdq.size() != 0) ? rdq.pop_front() : 8'($urandom);
                    void'(beatq.pop_front());
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom);
                    wcnt++;
                end
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
        end
    end

    // Response monitor; rspValid in cycle k lands k-1 edges after the accepting edge.
    always @(negedge clk) begin
        if (!rst && a_rsp_valid) begin
            if (a_expq.size() == 0) check("a_unexpected_rsp", 32'd1, 32'd0);
            else begin
                ea = a_expq.pop_front();
                check("a_rsp_data", a_rsp_data, ea.data);
                check("a_rsp_err", {31'h0, a_rsp_err}, {31'h0, ea.err});
                check("a_rsp_latency", 32'(cyc - acc_cyc), 32'(ea.lat));
                a_chk_ready = 1'b1;
            end
        end else if (a_chk_ready) begin
            check("a_ready_after_rsp", {31'h0, a_req_ready}, 32'd1);
            a_chk_ready = 1'b0;
        end
        if (!rst && b_rsp_valid) begin
            if (b_expq.size() == 0) check("b_unexpected_rsp", 32'd1, 32'd0);
            else begin
                eb = b_expq.pop_front();
                check("b_rsp_data", b_rsp_data, eb.data);
                check("b_rsp_err", {31'h0, b_rsp_err}, {31'h0, eb.err});
                check("b_rsp_latency", 32'(cyc - acc_cyc), 32'(eb.lat));
            end
        end
    end

    task automatic send(input bit to_b, input bit we, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input bit wait_rsp);
        bit    err;
        int    n, t;
        rsp_t  e;
        beat_t b;
        err = exp_err(we, c, a, !to_b);
        n = nbeats(c);
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                b.addr = a + 32'(i);
                b.we   = we;
                b.wd   = wd[8*i +: 8];
                beatq.push_back(b);
                if (!we) rdq.push_back(rd[8*i +: 8]);
            end
        end
        e.data = (err || we) ? 32'h0 : ext(c, rd);
        e.err  = err;
        e.lat  = err ? 0 : n * (1 + wait_n);
        if (to_b) b_expq.push_back(e);
        else      a_expq.push_back(e);
        @(negedge clk);
        req_write = we; req_ctrl = c; req_addr = a; req_wdata = wd;
        if (to_b) b_req_valid = 1'b1;
        else      a_req_valid = 1'b1;
        t = 0;
        while (!(to_b ? b_req_ready : a_req_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        if (wait_rsp) begin
            t = 0;
            while ((a_expq.size() + b_expq.size()) != 0 && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) begin
                check("rsp_timeout", 32'd0, 32'd1);
                a_expq.delete(); b_expq.delete(); beatq.delete(); rdq.delete();
            end
            @(negedge clk);
        end
    endtask

    logic [2:0] legal_ctrl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        req_write = 1'b0; req_ctrl = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'h0, a_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'h0, a_rsp_err}, 32'd0);
        check("rst_rsp_data", a_rsp_data, 32'h0);
        check("rst_mem_req", {31'h0, a_mem_req}, 32'd0);
        check("rst_mem_we", {31'h0, a_mem_we}, 32'd0);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_wdata", {24'h0, a_mem_wdata}, 32'h0);
        rst = 1'b0;

        wait_n = 0;
        send(0, 1'b1, 3'd2, 32'h100, 32'hA1B2C3D4, 32'h0, 1);
        send(0, 1'b0, 3'd0, 32'h101, $urandom, 32'h80, 1);
        send(0, 1'b0, 3'd4, 32'h101, $urandom, 32'h80, 1);
        wait_n = 3;
        send(0, 1'b0, 3'd1, 32'h200, $urandom, 32'h0000F234, 1);
        wait_n = 0;
        send(0, 1'b0, 3'd2, 32'h202, $urandom, 32'h0, 1);
        send(0, 1'b1, 3'd5, 32'h300, $urandom, 32'h0, 1);
        send(0, 1'b0, 3'd3, 32'h300, $urandom, 32'h0, 1);
        send(0, 1'b0, 3'd1, 32'h201, $urandom, 32'h0, 1);
        send(1, 1'b0, 3'd2, 32'hFFFFFFFE, $urandom, 32'h11223344, 1);

        for (int k = 0; k < 8; k++) begin
            wait_n = $urandom_range(0, 2);
            send(0, 1'($urandom_range(0, 1)), legal_ctrl[$urandom_range(0, 4)],
                 32'h400 + 32'($urandom_range(0, 7)), $urandom, $urandom, 1);
        end

        wait_n = 0;
        send(0, 1'b0, 3'd2, 32'h500, $urandom, $urandom, 0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_mem_req", {31'h0, a_mem_req}, 32'd0);
        check("midrst_req_ready", {31'h0, a_req_ready}, 32'd1);
        a_expq.delete(); beatq.delete(); rdq.delete();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        send(0, 1'b0, 3'd0, 32'h600, $urandom, 32'h7F, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
- Load/store initiator between the core's data-access port and a byte-wide memory bus.
- Converts one byte, half-word or word request (signed or unsigned loads) into 1, 2 or 4 sequential little-endian byte beats with a req/ack handshake.
- Returns one assembled, sign- or zero-extended 32-bit response per request.
- Drives the byte-addressed data RAM when that RAM sits behind a multi-cycle bus.

Parameters:
ADDR_W, 32, width of request and memory addresses.
CHECK_ALIGN, 1, when 1, misaligned half/word requests are rejected with an error; when 0, they are performed byte-wise.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
reqValid  input  1  core request valid
reqReady  output  1  block can accept a request
reqWrite  input  1  1 = store, 0 = load
reqCtrl  input  3  000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
reqAddr  input  ADDR_W  byte address
reqWData  input  32  store data, low bytes used
rspValid  output  1  one-cycle response pulse
rspData  output  32  load result; 0 for stores and errors
rspErr  output  1  request rejected, qualified by rspValid
memReq  output  1  byte beat request
memWe  output  1  beat is a write
memAddr  output  ADDR_W  beat byte address
memWData  output  8  beat write byte
memAck  input  1  beat complete; memRData valid this cycle for reads
memRData  input  8  read byte

Behaviour:
- Reset (sync, active-high) at the next rising edge: state IDLE, reqReady=1, rspValid=0, rspErr=0, rspData=0, memReq=0, memWe=0, memAddr=0, memWData=0, beat counter=0, assembly register=0.
- Reset mid-transaction aborts it: no response is issued, and memReq is low the cycle after reset is sampled.
- States: IDLE, BEAT, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid, latch write, ctrl, address and wdata.
  - Beat count N: 1 for ctrl 000/100, 2 for 001/101, 4 for 010.
  - Error conditions:
    - ctrl is 011, 110 or 111;
    - a store with ctrl 100 or 101;
    - CHECK_ALIGN=1 and a half request with addr[0]=1;
    - CHECK_ALIGN=1 and a word request with addr[1:0]!=0.
  - On error, go to RESP with rspErr=1 and issue no memory beats.
  - Otherwise go to BEAT.
- BEAT:
  - memReq=1, memAddr=latched addr + i (modulo 2^ADDR_W, so it wraps), memWe=latched write, memWData=wdata byte i (bits 8i+7:8i).
  - All beat outputs stay stable until memAck.
  - memAck may arrive in the same cycle memReq rises.
  - On memAck for a read, store memRData into assembly byte i.
  - If i=N-1, go to RESP and drop memReq; otherwise increment i and keep memReq high with the next address.
- RESP:
  - rspValid=1 for exactly one cycle, then return to IDLE. reqReady=0.
  - rspData for loads:
    - ctrl 000: sign-extend bit 7;
    - ctrl 001: sign-extend bit 15;
    - ctrl 010: full word;
    - ctrl 100/101: zero-extend.
  - rspData=0 for stores and errors.
  - rspErr=0 except on the error path.
- reqReady=0 in BEAT and RESP. Requests presented then are not accepted; the core holds them.
- Latency (memAck same cycle as memReq):
  - request accepted at edge 0;
  - beats occupy cycles 1..N;
  - rspValid in cycle N+1;
  - reqReady high again in cycle N+2.
- Error path latency: rspValid in cycle 1.
- Wait states: each cycle memAck is low extends BEAT by one cycle, with no output change.
- memAck while memReq=0 is ignored.
- rspData and rspErr hold their values until the next response; only rspValid qualifies them.

Test Plan:
- Reset, then word store addr 0x100, wdata 0xA1B2C3D4, memAck tied 1 -> beats at 0x100..0x103 with bytes D4, C3, B2, A1; rspValid in cycle 5, rspErr=0.
- Load byte signed from 0x101 with memRData=0x80 -> rspData=0xFFFFFF80. Same with ctrl 100 -> rspData=0x00000080.
- Half load ctrl 001 from 0x200, bytes 0x34 then 0xF2, memAck delayed 3 cycles per beat -> rspData=0xFFFFF234, memAddr stable during each wait.
- CHECK_ALIGN=1, word load at 0x202 -> no memReq, rspValid in cycle 1, rspErr=1, rspData=0. Store with ctrl 101 -> same error behaviour.
- CHECK_ALIGN=0, word load at 0xFFFFFFFE -> beat addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Assert Reset during beat 2 of a word load -> memReq=0 next cycle, no rspValid, reqReady=1; a following byte load completes normally.
